wish_pack_core: RTL and testbench

Wishbone-style width packer. It accepts NUM_PACK consecutive DATA_WIDTH-bit source beats and concatenates them into one DATA_WIDTH*NUM_PACK destination word, with lane order selected by parameter. It forwards the OR of the beats' cycle tags (TGC). It sits between a narrow Wishbone master stream and a wide Wishbone slave consumer.

---
 rtl/wish_pack_core_pkg.sv | 17 +
 rtl/wish_pack_core_if.sv | 30 +++
 rtl/wish_pack_core.sv | 86 ++++++++
 tb/tb_wish_pack_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wish_pack_core_pkg.sv
// Shared types and lane-order helpers for the Wishbone width packer.
package wish_pack_core_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    function automatic int first_lane(input int little_endian, input int num_pack);
        return (little_endian != 0) ? 0 : num_pack - 1;
    endfunction

    function automatic int last_lane(input int little_endian, input int num_pack);
        return (little_endian != 0) ? num_pack - 1 : 0;
    endfunction

endpackage

// File: rtl/wish_pack_core_if.sv
// Narrow source stream plus wide destination word, as seen by the packer.
interface wish_pack_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4,
    parameter int TGC_WIDTH  = 2
);
    logic                           s_stb_i;
    logic                           s_cyc_i;
    logic                           s_ack_o;
    logic                           s_stall_o;
    logic [DATA_WIDTH-1:0]          s_dat_i;
    logic [TGC_WIDTH-1:0]           s_tgc_i;
    logic                           d_stb_o;
    logic                           d_cyc_o;
    logic                           d_ack_i;
    logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o;
    logic [TGC_WIDTH-1:0]           d_tgc_o;

    // Packer side: consumes the narrow beats, produces the wide word.
    modport slave (
        input  s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, d_ack_i,
        output s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o
    );

    // Environment side: narrow master and wide consumer.
    modport master (
        output s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, d_ack_i,
        input  s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o
    );
endinterface

// File: rtl/wish_pack_core.sv
// Packs NUM_PACK narrow Wishbone beats into one wide word and ORs their cycle tags.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_FILL | collecting beats into lanes; source may be acked
// ST_OUT  | packed word presented on d_*; source stalled until d_ack_i
module wish_pack_core
    import wish_pack_core_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wish_pack_core_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_PACK) + 1;
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(first_lane(LITTLE_ENDIAN, NUM_PACK));
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(last_lane(LITTLE_ENDIAN, NUM_PACK));

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [DATA_WIDTH*NUM_PACK-1:0] dat_q;
    logic [TGC_WIDTH-1:0]           tgc_q;
    logic                           stall;
    logic                           accept;

    assign stall         = rst_i | (state_q == ST_OUT);
    assign accept        = bus.s_stb_i & bus.s_cyc_i & ~stall;
    assign bus.s_stall_o = stall;
    assign bus.s_ack_o   = accept;
    assign bus.d_stb_o   = (state_q == ST_OUT);
    assign bus.d_cyc_o   = (state_q == ST_OUT);
    assign bus.d_dat_o   = dat_q;
    assign bus.d_tgc_o   = tgc_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = START_IDX;
                        state_d = ST_OUT;
                    end else if (LITTLE_ENDIAN != 0) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (bus.d_ack_i) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Lanes are never cleared between packets; only reset zeroes them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
            idx_q   <= START_IDX;
            dat_q   <= '0;
            tgc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                for (int i = 0; i < NUM_PACK; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        dat_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.s_dat_i;
                    end
                end
                tgc_q <= (idx_q == START_IDX) ? bus.s_tgc_i : (tgc_q | bus.s_tgc_i);
            end
        end
    end

endmodule

// File: tb/tb_wish_pack_core.sv
// Self-checking bench: two packers (little and big endian) on one shared stream.
module tb_wish_pack_core;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stb = 1'b0, cyc = 1'b0, d_ack = 1'b0;
    logic [DW-1:0] dat = '0;
    logic [TW-1:0] tgc = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    wish_pack_core_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) if_le ();
    wish_pack_core_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) if_be ();

    assign if_le.s_stb_i = stb;
    assign if_le.s_cyc_i = cyc;
    assign if_le.s_dat_i = dat;
    assign if_le.s_tgc_i = tgc;
    assign if_le.d_ack_i = d_ack;
    assign if_be.s_stb_i = stb;
    assign if_be.s_cyc_i = cyc;
    assign if_be.s_dat_i = dat;
    assign if_be.s_tgc_i = tgc;
    assign if_be.d_ack_i = d_ack;

    wish_pack_core #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1)) u_le (
        .clk_i(clk), .rst_i(rst), .bus(if_le.slave)
    );
    wish_pack_core #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(0)) u_be (
        .clk_i(clk), .rst_i(rst), .bus(if_be.slave)
    );

    // Reference: beats land in the k-th beat slot; lane mapping applied when forming words.
    logic [DW-1:0] m_lane_le [NP];
    logic [DW-1:0] m_lane_be [NP];
    logic [TW-1:0] m_tgc;
    int            m_cnt;
    bit            m_out;

    function automatic logic [DW*NP-1:0] word_of(input logic [DW-1:0] lanes [NP]);
        logic [DW*NP-1:0] w = '0;
        for (int i = 0; i < NP; i++) w = w | ((DW*NP)'(lanes[i]) << (i * DW));
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_lane_le[i] = '0;
                m_lane_be[i] = '0;
            end
            m_tgc = '0;
            m_cnt = 0;
            m_out = 1'b0;
        end else if (m_out) begin
            if (d_ack) m_out = 1'b0;
        end else if (stb && cyc) begin
            m_lane_le[m_cnt]      = dat;
            m_lane_be[NP-1-m_cnt] = dat;
            m_tgc = (m_cnt == 0) ? tgc : (m_tgc | tgc);
            m_cnt++;
            if (m_cnt == NP) begin
                m_cnt = 0;
                m_out = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_ack;
            exp_ack = stb & cyc & ~rst & ~m_out;
            chk("le_ack",   64'(if_le.s_ack_o),   64'(exp_ack));
            chk("be_ack",   64'(if_be.s_ack_o),   64'(exp_ack));
            chk("le_stall", 64'(if_le.s_stall_o), 64'(rst | m_out));
            chk("be_stall", 64'(if_be.s_stall_o), 64'(rst | m_out));
            chk("le_dstb",  64'(if_le.d_stb_o),   64'(m_out));
            chk("le_dcyc",  64'(if_le.d_cyc_o),   64'(m_out));
            chk("be_dstb",  64'(if_be.d_stb_o),   64'(m_out));
            chk("be_dcyc",  64'(if_be.d_cyc_o),   64'(m_out));
            chk("le_dat",   64'(if_le.d_dat_o),   64'(word_of(m_lane_le)));
            chk("be_dat",   64'(if_be.d_dat_o),   64'(word_of(m_lane_be)));
            chk("le_tgc",   64'(if_le.d_tgc_o),   64'(m_tgc));
            chk("be_tgc",   64'(if_be.d_tgc_o),   64'(m_tgc));
            chk("ack_and_stall", 64'(if_le.s_ack_o & if_le.s_stall_o), 64'(0));
            chk("ack_in_reset",  64'(if_le.s_ack_o & rst), 64'(0));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [TW-1:0] t);
        stb = 1'b1; cyc = 1'b1; dat = d; tgc = t;
        @(negedge clk);
        chk("beat_acked", 64'(if_le.s_ack_o), 64'(1));
        next_cycle();
        stb = 1'b0;
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic wait_dstb(input int budget);
        int k = 0;
        @(negedge clk);
        while (!if_le.d_stb_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk("dstb_timeout", 64'(k), 64'(0));
    endtask

    task automatic expect_word(input string name, input logic [31:0] le, input logic [31:0] be,
                               input logic [TW-1:0] t);
        chk({name, "_dstb"}, 64'(if_le.d_stb_o), 64'(1));
        chk({name, "_le"},   64'(if_le.d_dat_o), 64'(le));
        chk({name, "_be"},   64'(if_be.d_dat_o), 64'(be));
        chk({name, "_tgc"},  64'(if_le.d_tgc_o), 64'(t));
    endtask

    initial begin
        stb = 1'b1; cyc = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst_ack",   64'(if_le.s_ack_o),   64'(0));
        chk("rst_stall", 64'(if_le.s_stall_o), 64'(1));
        chk("rst_dat",   64'(if_le.d_dat_o),   64'(0));
        chk("rst_tgc",   64'(if_le.d_tgc_o),   64'(0));
        next_cycle();
        rst = 1'b0; stb = 1'b0; cyc = 1'b0;
        next_cycle();

        // Back-to-back packet
        beat(8'h11, 2'b00);
        beat(8'h22, 2'b01);
        beat(8'h33, 2'b00);
        beat(8'h44, 2'b10);
        @(negedge clk);
        expect_word("pkt1", 32'h44332211, 32'h11223344, 2'b11);
        chk("pkt1_stall", 64'(if_le.s_stall_o), 64'(1));

        // Consumer holds off while source keeps strobing
        stb = 1'b1; cyc = 1'b1; dat = 8'h99; tgc = 2'b11;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            chk("hold_ack", 64'(if_le.s_ack_o), 64'(0));
            expect_word("hold", 32'h44332211, 32'h11223344, 2'b11);
        end
        stb = 1'b0;
        d_ack = 1'b1;
        next_cycle();
        d_ack = 1'b0;
        @(negedge clk);
        chk("release_dstb", 64'(if_le.d_stb_o), 64'(0));

        // Gapped packet with a cyc drop mid-packet
        next_cycle();
        beat(8'h55, 2'b01);
        idle(1);
        beat(8'h66, 2'b00);
        cyc = 1'b0; stb = 1'b1;
        next_cycle();
        next_cycle();
        stb = 1'b0;
        beat(8'h77, 2'b00);
        idle(1);
        d_ack = 1'b1;
        beat(8'h88, 2'b01);
        wait_dstb(4);
        expect_word("gap", 32'h88776655, 32'h55667788, 2'b01);
        next_cycle();
        d_ack = 1'b0;

        // Reset mid-packet discards it
        beat(8'h01, 2'b11);
        beat(8'h02, 2'b11);
        rst = 1'b1; stb = 1'b1; cyc = 1'b1;
        @(negedge clk);
        chk("midrst_ack", 64'(if_le.s_ack_o), 64'(0));
        next_cycle();
        next_cycle();
        rst = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("postrst_dat", 64'(if_le.d_dat_o), 64'(0));
        chk("postrst_tgc", 64'(if_le.d_tgc_o), 64'(0));
        next_cycle();
        beat(8'hA1, 2'b00);
        beat(8'hA2, 2'b00);
        beat(8'hA3, 2'b00);
        beat(8'hA4, 2'b00);
        @(negedge clk);
        expect_word("fresh", 32'hA4A3A2A1, 32'hA1A2A3A4, 2'b00);
        d_ack = 1'b1;
        next_cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            stb   = ($urandom_range(0, 3) != 0);
            cyc   = ($urandom_range(0, 7) != 0);
            d_ack = ($urandom_range(0, 2) == 0);
            dat   = DW'($urandom_range(0, 255));
            tgc   = TW'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 99) == 0);
            next_cycle();
        end
        rst = 1'b0; stb = 1'b0; d_ack = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
